axi_burst_memory: RTL
=====================

Name: axi_burst_memory

Overview:
- AXI4 subordinate backed by a single-clock word RAM.
- Sits directly downstream of the FastVDMA data manager (DMATop read/write ports) and terminates its INCR/FIXED bursts locally.
- Lets DMA transfers be exercised at full handshake rate without round-tripping every beat through the Renode bus peripheral.
- Read and write channels run as independent state machines sharing one dual-port memory.

Parameters:
DataWidth, 32, data bus width in bits (32 or 64)
AddrWidth, 32, address bus width in bits
IdWidth, 4, AXI transaction ID width
MemWords, 1024, memory depth in DataWidth words (power of two)
BaseAddr, 0, byte address of word 0; must be aligned to MemWords*DataWidth/8

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
awid/arid  in  IdWidth  write/read address ID
awaddr/araddr  in  AddrWidth  start byte address
awlen/arlen  in  8  beats minus one
awsize/arsize  in  3  log2 bytes per beat
awburst/arburst  in  2  burst type
awvalid/arvalid  in  1  address valid
awready/arready  out  1  address ready
wdata  in  DataWidth  write data
wstrb  in  DataWidth/8  byte enables
wlast  in  1  last write beat
wvalid  in  1  write data valid
wready  out  1  write data ready
bid  out  IdWidth  echoed awid
bresp  out  2  write response
bvalid  out  1  response valid
bready  in  1  response ready
rid  out  IdWidth  echoed arid
rdata  out  DataWidth  read data
rresp  out  2  per-beat read response
rlast  out  1  last read beat
rvalid  out  1  read data valid
rready  in  1  read data ready

Behaviour:
- Reset is asynchronous and active-high. While reset is asserted, every output is 0.
- awready and arready rise on the first clock edge after reset deasserts.
- Memory contents are not cleared by reset.
- Reset mid-burst aborts the burst immediately. No response is issued for an aborted burst.
- Write FSM, IDLE -> DATA -> RESP -> IDLE:
  - IDLE: awready=1. On awvalid&awready, latch id, addr, len, size, burst; set beat counter = 0; move to DATA.
  - DATA: wready=1. Each wvalid&wready writes the byte lanes selected by wstrb at the current word, then advances the address.
  - The burst always ends after exactly len+1 beats; then move to RESP.
  - RESP: bvalid=1, bid = latched ID. Hold until bready, then return to IDLE.
- Read FSM, IDLE -> DATA -> IDLE:
  - IDLE: arready=1. On handshake, register mem[addr0] into rdata and set rvalid=1 on that same edge (latency: rvalid high the cycle after ar handshake).
  - DATA: on each rvalid&rready, load the next beat on the same edge. With rready held high, beats are back-to-back with no bubbles.
  - rlast=1 on beat len. After its handshake, return to IDLE with rvalid=0.
  - rdata, rresp and rlast stay stable while rvalid=1 and rready=0.
- Address arithmetic:
  - word index = ((addr - BaseAddr) >> log2(DataWidth/8)) mod MemWords.
  - INCR: addr += 2^size per beat, computed at AddrWidth bits; wraps modulo 2^AddrWidth.
  - FIXED: addr held for all beats.
- Response codes (OKAY=0, SLVERR=2, DECERR=3):
  - DECERR: beat address outside [BaseAddr, BaseAddr+MemWords*DataWidth/8). The write is dropped; the read returns 0.
  - SLVERR: burst type WRAP or reserved (2'b10/2'b11), or size > log2(DataWidth/8). The whole burst is accepted but writes are dropped and reads return 0.
  - SLVERR: wlast mismatch, i.e. wlast=1 before beat len, or wlast=0 on beat len. Data is still written.
  - rresp is evaluated per beat.
  - bresp is the first error seen in the burst (sticky), otherwise OKAY.
- Simultaneous read and write to the same word in one cycle: the read returns the old data (read-first).
- No outstanding transactions beyond one per channel. A new aw is not accepted until b completes; a new ar is not accepted until the rlast handshake.

Test Plan:
- Reset, then write 4-beat INCR at BaseAddr+0x10, awid=3, data 0x11111111..0x44444444, wstrb=0xF -> wready 4 cycles, bvalid with bid=3, bresp=0.
- Read back the same burst with arid=5 and rready held high -> rvalid the cycle after ar handshake; 4 consecutive beats 0x11111111..0x44444444; rid=5; rlast only on beat 4; rresp=0.
- FIXED 3-beat write to BaseAddr+0x20, wstrb=0x3 then 0xC, rready toggling on read -> final word = merged bytes; rdata held stable during stall cycles.
- Write beyond BaseAddr+MemWords*4 with len=1 -> 2 beats accepted, bresp=3, memory unchanged. wlast early on a len=3 burst -> bresp=2, all 4 beats still accepted.
- arsize=3 on a 32-bit bus -> rresp=2 on every beat, rdata=0.
- Assert reset mid-read on beat 2 of 8 -> rvalid=0 immediately; arready=1 on the first edge after release; the next read returns prior memory contents.

Source files
------------

// File: rtl/axi_burst_memory.sv
// AXI4 subordinate terminating INCR/FIXED bursts in a local dual-port word RAM.
// Write and read channels are independent FSMs. Each channel accepts one
// transaction at a time. The read port is read-first against same-cycle writes.
module axi_burst_memory #(
    parameter int          DataWidth = 32,
    parameter int          AddrWidth = 32,
    parameter int          IdWidth   = 4,
    parameter int          MemWords  = 1024,
    parameter logic [63:0] BaseAddr  = 64'h0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [IdWidth-1:0]     awid,
    input  logic [AddrWidth-1:0]   awaddr,
    input  logic [7:0]             awlen,
    input  logic [2:0]             awsize,
    input  logic [1:0]             awburst,
    input  logic                   awvalid,
    output logic                   awready,
    input  logic [DataWidth-1:0]   wdata,
    input  logic [DataWidth/8-1:0] wstrb,
    input  logic                   wlast,
    input  logic                   wvalid,
    output logic                   wready,
    output logic [IdWidth-1:0]     bid,
    output logic [1:0]             bresp,
    output logic                   bvalid,
    input  logic                   bready,
    input  logic [IdWidth-1:0]     arid,
    input  logic [AddrWidth-1:0]   araddr,
    input  logic [7:0]             arlen,
    input  logic [2:0]             arsize,
    input  logic [1:0]             arburst,
    input  logic                   arvalid,
    output logic                   arready,
    output logic [IdWidth-1:0]     rid,
    output logic [DataWidth-1:0]   rdata,
    output logic [1:0]             rresp,
    output logic                   rlast,
    output logic                   rvalid,
    input  logic                   rready
);
    localparam int Bytes     = DataWidth / 8;
    localparam int ByteShift = $clog2(Bytes);
    localparam int IdxW      = $clog2(MemWords);
    localparam logic [AddrWidth-1:0] Base = BaseAddr[AddrWidth-1:0];
    localparam logic [AddrWidth:0]   Span = (AddrWidth + 1)'(MemWords * Bytes);
    localparam logic [1:0] RespOkay = 2'd0;
    localparam logic [1:0] RespSlv  = 2'd2;
    localparam logic [1:0] RespDec  = 2'd3;

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} wstate_t;
    typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} rstate_t;

    // WRAP and reserved burst types, and beats wider than the bus, are unsupported.
    function automatic logic burst_bad(input logic [1:0] burst, input logic [2:0] size);
        return (burst[1] == 1'b1) || (size > 3'(ByteShift));
    endfunction

    // Offset is unsigned, so addresses below the base wrap high and fail the check.
    function automatic logic in_range(input logic [AddrWidth-1:0] a);
        logic [AddrWidth:0] off;
        off = {1'b0, a - Base};
        return off < Span;
    endfunction

    function automatic logic [IdxW-1:0] word_idx(input logic [AddrWidth-1:0] a);
        return IdxW'((a - Base) >> ByteShift);
    endfunction

    // FIXED holds the address. Other types step by the beat size with natural wrap.
    function automatic logic [AddrWidth-1:0] next_addr(input logic [AddrWidth-1:0] a,
                                                       input logic [2:0] size,
                                                       input logic [1:0] burst);
        if (burst == 2'b00) begin
            return a;
        end else begin
            return a + (AddrWidth'(1) << size);
        end
    endfunction

    logic [DataWidth-1:0] mem_r [MemWords];

    // ---------------- write channel ----------------
    wstate_t              wstate_r, wnext_s;
    logic [IdWidth-1:0]   wid_r;
    logic [AddrWidth-1:0] waddr_r;
    logic [7:0]           wlen_r, wbeat_r;
    logic [2:0]           wsize_r;
    logic [1:0]           wburst_r, werr_r, w_beat_err_s;
    logic                 awready_r, wready_r, bvalid_r;
    logic                 aw_hs_s, w_hs_s, w_last_beat_s, w_bad_s, w_oor_s, mem_we_s;

    // Write beat classification: the drop decision and the response code for this beat.
    always_comb begin
        w_hs_s        = wready_r & wvalid;
        w_last_beat_s = (wbeat_r == wlen_r);
        w_bad_s       = burst_bad(wburst_r, wsize_r);
        w_oor_s       = !in_range(waddr_r);
        mem_we_s      = w_hs_s & !w_bad_s & !w_oor_s;
        if (w_bad_s) begin
            w_beat_err_s = RespSlv;
        end else if (w_oor_s) begin
            w_beat_err_s = RespDec;
        end else if (wlast != w_last_beat_s) begin
            w_beat_err_s = RespSlv;
        end else begin
            w_beat_err_s = RespOkay;
        end
    end

    // Write FSM next-state logic.
    always_comb begin
        wnext_s = wstate_r;
        aw_hs_s = 1'b0;
        case (wstate_r)
            W_IDLE: begin
                aw_hs_s = awvalid & awready_r;
                if (aw_hs_s) wnext_s = W_DATA;
                else         wnext_s = W_IDLE;
            end
            W_DATA: begin
                if (w_hs_s && w_last_beat_s) wnext_s = W_RESP;
                else                         wnext_s = W_DATA;
            end
            W_RESP: begin
                if (bvalid_r && bready) wnext_s = W_IDLE;
                else                    wnext_s = W_RESP;
            end
            default: wnext_s = W_IDLE;
        endcase
    end

    // Write FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) wstate_r <= W_IDLE;
        else       wstate_r <= wnext_s;
    end

    // Write channel handshake outputs, burst context and sticky first error.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            awready_r <= 1'b0;
            wready_r  <= 1'b0;
            bvalid_r  <= 1'b0;
            wid_r     <= '0;
            waddr_r   <= '0;
            wlen_r    <= 8'd0;
            wsize_r   <= 3'd0;
            wburst_r  <= 2'd0;
            wbeat_r   <= 8'd0;
            werr_r    <= RespOkay;
        end else begin
            awready_r <= (wnext_s == W_IDLE);
            wready_r  <= (wnext_s == W_DATA);
            bvalid_r  <= (wnext_s == W_RESP);
            if (aw_hs_s) begin
                wid_r    <= awid;
                waddr_r  <= awaddr;
                wlen_r   <= awlen;
                wsize_r  <= awsize;
                wburst_r <= awburst;
                wbeat_r  <= 8'd0;
                werr_r   <= RespOkay;
            end else if (w_hs_s) begin
                waddr_r <= next_addr(waddr_r, wsize_r, wburst_r);
                wbeat_r <= wbeat_r + 8'd1;
                if (werr_r == RespOkay) werr_r <= w_beat_err_s;
            end
        end
    end

    // Byte-lane write port. The RAM has no reset, so its contents survive a reset.
    always_ff @(posedge clock) begin
        if (mem_we_s) begin
            for (int b = 0; b < Bytes; b++) begin
                if (wstrb[b]) mem_r[word_idx(waddr_r)][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign awready = awready_r;
    assign wready  = wready_r;
    assign bvalid  = bvalid_r;
    assign bid     = wid_r;
    assign bresp   = werr_r;

    // ---------------- read channel ----------------
    rstate_t              rstate_r, rnext_s;
    logic [IdWidth-1:0]   rid_r;
    logic [AddrWidth-1:0] raddr_r, rd_addr_s;
    logic [7:0]           rlen_r, rbeat_r;
    logic [2:0]           rsize_r, rd_size_s;
    logic [1:0]           rburst_r, rd_burst_s, rresp_r, rd_resp_s;
    logic [DataWidth-1:0] rdata_r;
    logic                 arready_r, rvalid_r, rlast_r;
    logic                 ar_hs_s, r_hs_s, rd_load_s, rd_err_s;

    // Selects the beat to load: the AR request itself, or the next beat of the burst.
    always_comb begin
        ar_hs_s   = (rstate_r == R_IDLE) & arvalid & arready_r;
        r_hs_s    = rvalid_r & rready;
        rd_load_s = ar_hs_s | (r_hs_s & !rlast_r);
        if (ar_hs_s) begin
            rd_addr_s  = araddr;
            rd_size_s  = arsize;
            rd_burst_s = arburst;
        end else begin
            rd_addr_s  = raddr_r;
            rd_size_s  = rsize_r;
            rd_burst_s = rburst_r;
        end
        if (burst_bad(rd_burst_s, rd_size_s)) begin
            rd_resp_s = RespSlv;
        end else if (!in_range(rd_addr_s)) begin
            rd_resp_s = RespDec;
        end else begin
            rd_resp_s = RespOkay;
        end
        rd_err_s = (rd_resp_s != RespOkay);
    end

    // Read FSM next-state logic.
    always_comb begin
        rnext_s = rstate_r;
        case (rstate_r)
            R_IDLE: begin
                if (ar_hs_s) rnext_s = R_DATA;
                else         rnext_s = R_IDLE;
            end
            R_DATA: begin
                if (r_hs_s && rlast_r) rnext_s = R_IDLE;
                else                   rnext_s = R_DATA;
            end
            default: rnext_s = R_IDLE;
        endcase
    end

    // Read FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) rstate_r <= R_IDLE;
        else       rstate_r <= rnext_s;
    end

    // Read beat registers. They load only on the AR handshake or the R handshake, so they hold during stalls.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            arready_r <= 1'b0;
            rvalid_r  <= 1'b0;
            rid_r     <= '0;
            raddr_r   <= '0;
            rlen_r    <= 8'd0;
            rsize_r   <= 3'd0;
            rburst_r  <= 2'd0;
            rbeat_r   <= 8'd0;
            rdata_r   <= '0;
            rresp_r   <= RespOkay;
            rlast_r   <= 1'b0;
        end else begin
            arready_r <= (rnext_s == R_IDLE);
            rvalid_r  <= (rnext_s == R_DATA);
            if (ar_hs_s) begin
                rid_r    <= arid;
                rlen_r   <= arlen;
                rsize_r  <= arsize;
                rburst_r <= arburst;
            end
            if (rd_load_s) begin
                rdata_r <= rd_err_s ? '0 : mem_r[word_idx(rd_addr_s)];
                rresp_r <= rd_resp_s;
                rlast_r <= ar_hs_s ? (arlen == 8'd0) : (rbeat_r + 8'd1 == rlen_r);
                rbeat_r <= ar_hs_s ? 8'd0 : rbeat_r + 8'd1;
                raddr_r <= next_addr(rd_addr_s, rd_size_s, rd_burst_s);
            end else if (r_hs_s) begin
                rlast_r <= 1'b0;
            end
        end
    end

    assign arready = arready_r;
    assign rvalid  = rvalid_r;
    assign rid     = rid_r;
    assign rdata   = rdata_r;
    assign rresp   = rresp_r;
    assign rlast   = rlast_r;
endmodule
